// File: rtl/mac_vec_acc_if.sv
// mac_vec_acc_if: handshake/data bundle for the multi-lane MAC engine.
// Groups configuration, operand stream (valid/ready), result stream
// (valid/ready) and status signals. The master modport drives operands and
// configuration. The slave modport is the engine side.
//   cfg_valid/cfg_signed/cfg_sat/cfg_len : job configuration load
//   clear                                : synchronous abort of the current job
//   in_valid/in_ready/in_a/in_b          : operand beats, LANES lanes per beat
//   out_valid/out_ready/out_data/out_ovf : accumulated result per lane
//   busy/error                           : engine status, illegal-config pulse
interface mac_vec_acc_if #(
    parameter int LANES  = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
);
    logic                      cfg_valid;
    logic                      cfg_signed;
    logic                      cfg_sat;
    logic [LEN_W-1:0]          cfg_len;
    logic                      clear;
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*DATA_W-1:0]   in_a;
    logic [LANES*DATA_W-1:0]   in_b;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*ACC_W-1:0]    out_data;
    logic [LANES-1:0]          out_ovf;
    logic                      busy;
    logic                      error;

    modport master (
        output cfg_valid, cfg_signed, cfg_sat, cfg_len, clear,
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, busy, error
    );

    modport slave (
        input  cfg_valid, cfg_signed, cfg_sat, cfg_len, clear,
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_ovf, busy, error
    );
endinterface

// File: rtl/mac_vec_acc.sv
// mac_vec_acc: LANES-wide integer multiply-accumulate engine.
// Each accepted beat registers LANES products (stage 1). The following cycle
// adds them into per-lane ACC_W accumulators with sticky overflow and optional
// saturation. After cfg_len beats the result is held on the output port until
// out_ready. ACC_W must be at least 2*DATA_W.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : mac_vec_acc_if slave port (config, operands, result, status)
module mac_vec_acc #(
    parameter int LANES  = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    mac_vec_acc_if.slave  bus
);
    localparam int PW = 2 * DATA_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [LEN_W-1:0]       cnt_q, cnt_d;
    logic                   cfg_sgn_q, cfg_sgn_d;
    logic                   cfg_sat_q, cfg_sat_d;
    logic [LEN_W-1:0]       cfg_len_q, cfg_len_d;
    logic                   s1_valid_q, s1_valid_d;
    logic                   s1_sgn_q, s1_sgn_d;
    logic                   s1_sat_q, s1_sat_d;
    logic [LANES*PW-1:0]    prod_q, prod_d;
    logic [LANES*ACC_W-1:0] acc_q, acc_d;
    logic [LANES-1:0]       ovf_q, ovf_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic                   busy_q, busy_d;
    logic                   error_q, error_d;

    logic                   accept_s;
    logic [LEN_W-1:0]       cnt_inc_s;
    logic [LANES*PW-1:0]    prod_s;
    logic [PW-1:0]          opa_s [LANES];
    logic [PW-1:0]          opb_s [LANES];
    logic [ACC_W-1:0]       ext_s [LANES];
    logic [ACC_W:0]         sum_s [LANES];
    logic [LANES*ACC_W-1:0] acc_sum_s;
    logic [LANES-1:0]       ovf_new_s;

    // Clamp value for an overflowing lane; neg selects the signed minimum.
    function automatic logic [ACC_W-1:0] sat_value(input logic is_signed, input logic neg);
        logic [ACC_W-1:0] v;
        if (!is_signed) begin
            v = {ACC_W{1'b1}};
        end else if (neg) begin
            v = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            v = {1'b0, {(ACC_W-1){1'b1}}};
        end
        return v;
    endfunction

    assign accept_s  = bus.in_valid && in_ready_q && !bus.clear;
    assign cnt_inc_s = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};

    // Stage-1 products: operands widened to PW bits, so the low PW bits of the
    // product are correct for both signed and unsigned interpretation.
    always_comb begin
        prod_s = {(LANES*PW){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if (cfg_sgn_q) begin
                opa_s[i] = {{DATA_W{bus.in_a[i*DATA_W+DATA_W-1]}}, bus.in_a[i*DATA_W +: DATA_W]};
                opb_s[i] = {{DATA_W{bus.in_b[i*DATA_W+DATA_W-1]}}, bus.in_b[i*DATA_W +: DATA_W]};
            end else begin
                opa_s[i] = {{DATA_W{1'b0}}, bus.in_a[i*DATA_W +: DATA_W]};
                opb_s[i] = {{DATA_W{1'b0}}, bus.in_b[i*DATA_W +: DATA_W]};
            end
            prod_s[i*PW +: PW] = opa_s[i] * opb_s[i];
        end
    end

    // Accumulator adders with per-lane overflow detection and saturation.
    always_comb begin
        acc_sum_s = acc_q;
        ovf_new_s = {LANES{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if (s1_sgn_q) begin
                ext_s[i] = ACC_W'($signed(prod_q[i*PW +: PW]));
            end else begin
                ext_s[i] = ACC_W'(prod_q[i*PW +: PW]);
            end
            sum_s[i] = {1'b0, acc_q[i*ACC_W +: ACC_W]} + {1'b0, ext_s[i]};
            if (s1_sgn_q) begin
                ovf_new_s[i] = (acc_q[i*ACC_W+ACC_W-1] == ext_s[i][ACC_W-1]) &&
                               (sum_s[i][ACC_W-1] != acc_q[i*ACC_W+ACC_W-1]);
            end else begin
                ovf_new_s[i] = sum_s[i][ACC_W];
            end
            if (ovf_new_s[i] && s1_sat_q) begin
                acc_sum_s[i*ACC_W +: ACC_W] = sat_value(s1_sgn_q, acc_q[i*ACC_W+ACC_W-1]);
            end else begin
                acc_sum_s[i*ACC_W +: ACC_W] = sum_s[i][ACC_W-1:0];
            end
        end
    end

    // Control FSM, configuration load, beat counting and accumulator update.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cfg_sgn_d  = cfg_sgn_q;
        cfg_sat_d  = cfg_sat_q;
        cfg_len_d  = cfg_len_q;
        s1_valid_d = 1'b0;
        s1_sgn_d   = s1_sgn_q;
        s1_sat_d   = s1_sat_q;
        prod_d     = prod_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        error_d    = 1'b0;
        if (bus.clear) begin
            // Abort wins over everything; configuration is kept.
            state_d = ST_IDLE;
            cnt_d   = {LEN_W{1'b0}};
            acc_d   = {(LANES*ACC_W){1'b0}};
            ovf_d   = {LANES{1'b0}};
        end else begin
            if (s1_valid_q) begin
                acc_d = acc_sum_s;
                ovf_d = ovf_q | ovf_new_s;
            end else begin
                acc_d = acc_q;
            end
            if (accept_s) begin
                prod_d     = prod_s;
                s1_valid_d = 1'b1;
                s1_sgn_d   = cfg_sgn_q;
                s1_sat_d   = cfg_sat_q;
                cnt_d      = cnt_inc_s;
            end else begin
                s1_valid_d = 1'b0;
            end
            if (bus.cfg_valid) begin
                if ((state_q == ST_IDLE) && (bus.cfg_len != {LEN_W{1'b0}})) begin
                    cfg_sgn_d = bus.cfg_signed;
                    cfg_sat_d = bus.cfg_sat;
                    cfg_len_d = bus.cfg_len;
                end else begin
                    error_d = 1'b1;
                end
            end else begin
                error_d = 1'b0;
            end
            case (state_q)
                ST_IDLE, ST_RUN: begin
                    if (accept_s) begin
                        state_d = (cnt_inc_s == cfg_len_q) ? ST_DRAIN : ST_RUN;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_DRAIN: begin
                    // Stay while the last product is still being added.
                    if (s1_valid_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        state_d = ST_IDLE;
                        cnt_d   = {LEN_W{1'b0}};
                        acc_d   = {(LANES*ACC_W){1'b0}};
                        ovf_d   = {LANES{1'b0}};
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        in_ready_d  = (state_d == ST_IDLE) || (state_d == ST_RUN);
        busy_d      = (state_d != ST_IDLE);
        out_valid_d = (state_d == ST_HOLD);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {LEN_W{1'b0}};
            cfg_sgn_q   <= 1'b0;
            cfg_sat_q   <= 1'b0;
            cfg_len_q   <= {{(LEN_W-1){1'b0}}, 1'b1};
            s1_valid_q  <= 1'b0;
            s1_sgn_q    <= 1'b0;
            s1_sat_q    <= 1'b0;
            prod_q      <= {(LANES*PW){1'b0}};
            acc_q       <= {(LANES*ACC_W){1'b0}};
            ovf_q       <= {LANES{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cfg_sgn_q   <= cfg_sgn_d;
            cfg_sat_q   <= cfg_sat_d;
            cfg_len_q   <= cfg_len_d;
            s1_valid_q  <= s1_valid_d;
            s1_sgn_q    <= s1_sgn_d;
            s1_sat_q    <= s1_sat_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.busy      = busy_q;
    assign bus.error     = error_q;
endmodule

// File: doc/mac_vec_acc.md
# mac_vec_acc

Parametrised multi-lane integer multiply-accumulate engine, successor to the single-lane config/valid/read MAC wrapper. Accepts LANES operand pairs per beat over a valid/ready handshake and accumulates a configured number of beats into per-lane ACC_W accumulators, using a registered product stage. It then presents the results on a valid/ready output port. It sits between the operand streamer and the result writeback in the MAC datapath.

## Interface
- LANES, 4, number of parallel MAC lanes
- DATA_W, 8, operand width per lane
- ACC_W, 24, accumulator width per lane; legal only if ACC_W >= 2*DATA_W
- LEN_W, 8, width of the beat-count configuration
- clk  input  1  clock; all logic on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- cfg_valid  input  1  load configuration this cycle
- cfg_signed  input  1  1: two's-complement operands, 0: unsigned
- cfg_sat  input  1  1: saturate accumulators, 0: wrap
- cfg_len  input  LEN_W  beats per job, 1..2^LEN_W-1
- clear  input  1  synchronous abort: flush the job and zero the accumulators
- in_valid  input  1  operand beat valid
- in_ready  output  1  engine can accept a beat
- in_a, in_b  input  LANES*DATA_W  operands; lane i occupies bits [i*DATA_W +: DATA_W]
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_data  output  LANES*ACC_W  accumulators; lane i occupies bits [i*ACC_W +: ACC_W]
- out_ovf  output  LANES  sticky per-lane overflow flag for the current job
- busy  output  1  state is not IDLE
- error  output  1  one-cycle pulse on an illegal configuration attempt

## Operation
- FSM states: IDLE, RUN, DRAIN, HOLD. in_ready = (state==IDLE or RUN). busy = (state!=IDLE).
- Beat accept: in_valid && in_ready at a clock edge. Each accept registers LANES products into stage 1 together with a stage-1 valid bit and increments the beat counter.
- IDLE -> RUN on the first accept. If cfg_len==1, IDLE -> DRAIN on that accept.
- RUN -> DRAIN on the accept that makes beat count == cfg_len.
- DRAIN -> HOLD after one cycle, once the final product has been added.
- HOLD -> IDLE on out_ready. That edge zeroes the accumulators, out_ovf and the beat counter.
- Accumulate: when stage-1 valid is set, acc_i <= acc_i + ext(prod_i). ext() sign-extends if cfg_signed is 1 and zero-extends otherwise. Product width is 2*DATA_W.
- Overflow detection:
  - Signed: operands have equal sign and the sum sign differs.
  - Unsigned: carry out of ACC_W.
- Overflow response: set out_ovf[i] (sticky). With cfg_sat=1, clamp acc_i to the signed max/min, or to 2^ACC_W-1 for unsigned. With cfg_sat=0, keep the wrapped value.
- Configuration:
  - cfg_valid in IDLE with cfg_len != 0 loads signed, sat and len.
  - cfg_valid in IDLE with cfg_len==0, or cfg_valid in any other state: configuration unchanged and error pulses for 1 cycle.
  - Configuration is used from the next accepted beat.
- clear, in any state:
  - Takes priority over beat accept, cfg_valid and the output handshake.
  - Next state IDLE; accumulators, out_ovf, stage-1 valid and beat counter zeroed.
  - Any beat offered in the same cycle is not accepted.
- out_data and out_ovf stay stable for the whole time out_valid is high.

## Timing
- Reset values: in_ready 1 after release (state IDLE), out_valid 0, out_data 0, out_ovf 0, busy 0, error 0. Configuration resets to signed=0, sat=0, len=1.
- Latency: last beat accepted at edge k; accumulator final at edge k+1; out_valid high from edge k+2 (state HOLD).
- out_valid = (state==HOLD), registered. Deasserts at the edge where out_ready is sampled high.
- Back-to-back jobs: the first beat of the next job can be accepted one cycle after the out handshake (IDLE). Minimum job period is cfg_len+3 cycles.
- Backpressure: while in HOLD, in_ready is 0 and in_valid is ignored.
- Asynchronous rst_n assertion mid-job clears all state immediately. No partial result is ever presented.

## Test plan
- Unsigned, len=3, lane0 a=2 b=3 on every beat, other lanes 0 -> out_valid 2 cycles after the last accept. lane0=18, others 0, out_ovf=0.
- Signed, len=2, lane1 a=0x80 b=0x7F -> lane1=0xFF8100 (-32512), out_ovf=0.
- ACC_W=16 unsigned, len=2, a=b=0xFF:
  - sat=1 -> 0xFFFF with out_ovf=1.
  - sat=0 -> 0xFC02 with out_ovf=1.
- Hold out_ready low for 5 cycles in HOLD while driving in_valid=1 -> out_data stable, in_ready=0, no beats counted. Release -> the next job's result is unaffected by the previous job.
- Configuration errors:
  - cfg_valid during RUN -> error pulse for 1 cycle, result uses the old configuration.
  - cfg_len=0 in IDLE -> error pulse, length unchanged.
- Interruptions:
  - clear after beat 2 of a len=4 job -> IDLE with accumulators 0; a fresh 4-beat job returns the correct sum.
  - rst_n pulsed mid-RUN -> all outputs at reset values.
